alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 36 +++
 rtl/alu_arbiter.sv | 175 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
//   - arb_state_e : FSM state encoding (idle, issue, wait, response)
//   - CMD_MUL / CMD_MUL_T : multiply command codes (valid with MODE=1)
//   - DEF_LAT / DEF_MUL_LAT : default ALU latencies in cycles
package alu_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  localparam logic [3:0] CMD_MUL   = 4'b1001;
  localparam logic [3:0] CMD_MUL_T = 4'b1010;

  localparam int unsigned DEF_LAT     = 2;
  localparam int unsigned DEF_MUL_LAT = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset; last grant = requester 1
//   req_i  : request per requester
//   hs_i   : a grant was accepted this cycle; updates the last-grant pointer
//   gnt_o  : one-hot grant, or zero when nothing requests
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       hs_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // Contention goes to whoever was not served last.
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (hs_i) begin
      last_q <= gnt_o[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one pipelined ALU, one operation in flight.
//   CLK, RST           : clock and synchronous active-high reset
//   REQ_*              : per-requester request channel (valid/ready handshake, operands)
//   ALU_*  (out)       : latched operation, ALU_CE high while the ALU must see it
//   ALU_*  (in)        : ALU results and flags, sampled at the end of the last held cycle
//   RSP_*              : one-cycle response pulse with owner id, result data and flags
//                        RSP_FLAGS = {COUT, OFLOW, G, E, L, ERR}
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned C_WIDTH = 4,
  parameter int unsigned LAT     = DEF_LAT,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [1:0]           REQ_VALID,
  output logic [1:0]           REQ_READY,
  input  logic [2*WIDTH-1:0]   REQ_OPA,
  input  logic [2*WIDTH-1:0]   REQ_OPB,
  input  logic [2*C_WIDTH-1:0] REQ_CMD,
  input  logic [1:0]           REQ_MODE,
  input  logic [1:0]           REQ_CIN,
  input  logic [3:0]           REQ_IN_VALID,
  output logic [WIDTH-1:0]     ALU_OPA,
  output logic [WIDTH-1:0]     ALU_OPB,
  output logic [C_WIDTH-1:0]   ALU_CMD,
  output logic                 ALU_MODE,
  output logic                 ALU_CIN,
  output logic                 ALU_CE,
  output logic [1:0]           ALU_IN_VALID,
  input  logic [WIDTH:0]       ALU_RES,
  input  logic [2*WIDTH-1:0]   ALU_MUL_RES,
  input  logic                 ALU_COUT,
  input  logic                 ALU_OFLOW,
  input  logic                 ALU_G,
  input  logic                 ALU_E,
  input  logic                 ALU_L,
  input  logic                 ALU_ERR,
  output logic                 RSP_VALID,
  output logic                 RSP_ID,
  output logic [WIDTH:0]       RSP_RES,
  output logic [2*WIDTH-1:0]   RSP_MUL_RES,
  output logic [5:0]           RSP_FLAGS
);

  localparam int unsigned MaxLat = (MUL_LAT > LAT) ? MUL_LAT : LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);

  arb_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [1:0] gnt;
  logic       hs;
  logic       sel;
  logic       load;
  logic       capture;

  logic [WIDTH-1:0]   sel_opa, sel_opb;
  logic [C_WIDTH-1:0] sel_cmd;
  logic               sel_mode, sel_cin, sel_mul;
  logic [1:0]         sel_inv;
  logic [CntW-1:0]    sel_lat;

  logic [WIDTH-1:0]   opa_q, opb_q;
  logic [C_WIDTH-1:0] cmd_q;
  logic               mode_q, cin_q, id_q;
  logic [1:0]         inv_q;
  logic [WIDTH:0]     rsp_res_q;
  logic [2*WIDTH-1:0] rsp_mul_q;
  logic [5:0]         rsp_flags_q;

  rr_arb2 u_rr_arb2 (
    .clk_i (CLK),
    .rst_i (RST),
    .req_i (REQ_VALID),
    .hs_i  (hs),
    .gnt_o (gnt)
  );

  // Ready is only offered while idle and never while reset is asserted.
  assign REQ_READY = (state_q == StIdle && !RST) ? gnt : 2'b00;
  assign hs        = |(REQ_VALID & REQ_READY);
  assign sel       = gnt[1];

  always_comb begin
    sel_opa  = sel ? REQ_OPA[2*WIDTH-1:WIDTH]     : REQ_OPA[WIDTH-1:0];
    sel_opb  = sel ? REQ_OPB[2*WIDTH-1:WIDTH]     : REQ_OPB[WIDTH-1:0];
    sel_cmd  = sel ? REQ_CMD[2*C_WIDTH-1:C_WIDTH] : REQ_CMD[C_WIDTH-1:0];
    sel_mode = REQ_MODE[sel];
    sel_cin  = REQ_CIN[sel];
    sel_inv  = sel ? REQ_IN_VALID[3:2] : REQ_IN_VALID[1:0];
    sel_mul  = sel_mode && (sel_cmd == C_WIDTH'(CMD_MUL) || sel_cmd == C_WIDTH'(CMD_MUL_T));
    sel_lat  = sel_mul ? CntW'(MUL_LAT) : CntW'(LAT);
  end

  // cnt_q holds the number of held cycles remaining, including the current one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          load    = 1'b1;
          cnt_d   = sel_lat;
          state_d = StIssue;
        end
      end
      StIssue, StWait: begin
        if (cnt_q <= CntW'(1)) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = StResp;
        end else begin
          cnt_d   = cnt_q - CntW'(1);
          state_d = StWait;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      cmd_q       <= '0;
      mode_q      <= 1'b0;
      cin_q       <= 1'b0;
      inv_q       <= 2'b00;
      id_q        <= 1'b0;
      rsp_res_q   <= '0;
      rsp_mul_q   <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        opa_q  <= sel_opa;
        opb_q  <= sel_opb;
        cmd_q  <= sel_cmd;
        mode_q <= sel_mode;
        cin_q  <= sel_cin;
        inv_q  <= sel_inv;
        id_q   <= sel;
      end
      if (capture) begin
        rsp_res_q   <= ALU_RES;
        rsp_mul_q   <= ALU_MUL_RES;
        rsp_flags_q <= {ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR};
      end
    end
  end

  assign ALU_OPA      = opa_q;
  assign ALU_OPB      = opb_q;
  assign ALU_CMD      = cmd_q;
  assign ALU_MODE     = mode_q;
  assign ALU_CIN      = cin_q;
  assign ALU_CE       = (state_q == StIssue) || (state_q == StWait);
  assign ALU_IN_VALID = ALU_CE ? inv_q : 2'b00;

  assign RSP_VALID   = (state_q == StResp);
  assign RSP_ID      = id_q;
  assign RSP_RES     = rsp_res_q;
  assign RSP_MUL_RES = rsp_mul_q;
  assign RSP_FLAGS   = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small latency-aware ALU model.
module tb_alu_arbiter;

  localparam int W  = 8;
  localparam int CW = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic [1:0]      REQ_VALID, REQ_READY;
  logic [2*W-1:0]  REQ_OPA, REQ_OPB;
  logic [2*CW-1:0] REQ_CMD;
  logic [1:0]      REQ_MODE, REQ_CIN;
  logic [3:0]      REQ_IN_VALID;
  logic [W-1:0]    ALU_OPA, ALU_OPB;
  logic [CW-1:0]   ALU_CMD;
  logic            ALU_MODE, ALU_CIN, ALU_CE;
  logic [1:0]      ALU_IN_VALID;
  logic [W:0]      ALU_RES;
  logic [2*W-1:0]  ALU_MUL_RES;
  logic            ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR;
  logic            RSP_VALID, RSP_ID;
  logic [W:0]      RSP_RES;
  logic [2*W-1:0]  RSP_MUL_RES;
  logic [5:0]      RSP_FLAGS;

  alu_arbiter #(
    .WIDTH   (W),
    .C_WIDTH (CW),
    .LAT     (2),
    .MUL_LAT (3)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .REQ_VALID    (REQ_VALID),
    .REQ_READY    (REQ_READY),
    .REQ_OPA      (REQ_OPA),
    .REQ_OPB      (REQ_OPB),
    .REQ_CMD      (REQ_CMD),
    .REQ_MODE     (REQ_MODE),
    .REQ_CIN      (REQ_CIN),
    .REQ_IN_VALID (REQ_IN_VALID),
    .ALU_OPA      (ALU_OPA),
    .ALU_OPB      (ALU_OPB),
    .ALU_CMD      (ALU_CMD),
    .ALU_MODE     (ALU_MODE),
    .ALU_CIN      (ALU_CIN),
    .ALU_CE       (ALU_CE),
    .ALU_IN_VALID (ALU_IN_VALID),
    .ALU_RES      (ALU_RES),
    .ALU_MUL_RES  (ALU_MUL_RES),
    .ALU_COUT     (ALU_COUT),
    .ALU_OFLOW    (ALU_OFLOW),
    .ALU_G        (ALU_G),
    .ALU_E        (ALU_E),
    .ALU_L        (ALU_L),
    .ALU_ERR      (ALU_ERR),
    .RSP_VALID    (RSP_VALID),
    .RSP_ID       (RSP_ID),
    .RSP_RES      (RSP_RES),
    .RSP_MUL_RES  (RSP_MUL_RES),
    .RSP_FLAGS    (RSP_FLAGS)
  );

  always #5 CLK = ~CLK;

  // ALU model: results are only correct during the last held cycle; garbage otherwise,
  // so a capture on the wrong edge shows up in the response data.
  int unsigned ce_cnt = 0;
  int unsigned cyc_now = 0;
  logic        m_mul, m_ok;
  int unsigned m_lat;

  always @(posedge CLK) begin
    ce_cnt  <= ALU_CE ? ce_cnt + 1 : 0;
    cyc_now <= cyc_now + 1;
  end

  always_comb begin
    m_mul       = ALU_MODE && (ALU_CMD == 4'b1001 || ALU_CMD == 4'b1010);
    m_lat       = m_mul ? 3 : 2;
    m_ok        = ALU_CE && (ce_cnt == m_lat - 1);
    ALU_RES     = 9'h1AA;
    ALU_MUL_RES = 16'hBEEF;
    ALU_COUT    = 1'b1;
    ALU_OFLOW   = 1'b1;
    ALU_G       = 1'b1;
    ALU_E       = 1'b1;
    ALU_L       = 1'b1;
    ALU_ERR     = 1'b1;
    if (m_ok) begin
      ALU_RES     = (ALU_MODE && ALU_CMD == 4'b0000) ?
                    ({1'b0, ALU_OPA} + {1'b0, ALU_OPB} + {8'h00, ALU_CIN}) : 9'h000;
      ALU_MUL_RES = m_mul ? (16'(ALU_OPA) * 16'(ALU_OPB)) : 16'h0000;
      ALU_COUT    = ALU_RES[8];
      ALU_OFLOW   = 1'b0;
      ALU_G       = ALU_OPA > ALU_OPB;
      ALU_E       = ALU_OPA == ALU_OPB;
      ALU_L       = ALU_OPA < ALU_OPB;
      ALU_ERR     = !ALU_MODE && ALU_CMD == 4'b1100;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input bit id, input logic [7:0] opa, input logic [7:0] opb,
                         input logic [3:0] cmd, input logic mode, input logic cin,
                         input logic [1:0] inv);
    REQ_OPA[id*8 +: 8]      = opa;
    REQ_OPB[id*8 +: 8]      = opb;
    REQ_CMD[id*4 +: 4]      = cmd;
    REQ_MODE[id]            = mode;
    REQ_CIN[id]             = cin;
    REQ_IN_VALID[id*2 +: 2] = inv;
  endtask

  // Called at a negedge; issues one request and checks latency and response contents.
  task automatic run_op(input string tag, input bit id, input logic [7:0] opa,
                        input logic [7:0] opb, input logic [3:0] cmd, input logic mode,
                        input logic [1:0] inv, input int exp_lat, input logic [8:0] exp_res,
                        input logic [15:0] exp_mul, input logic [5:0] exp_flags);
    int t;
    set_req(id, opa, opb, cmd, mode, 1'b0, inv);
    REQ_VALID[id] = 1'b1;
    #1;
    t = 0;
    while (REQ_READY[id] !== 1'b1 && t < 20) begin
      @(negedge CLK);
      t++;
    end
    check({tag, ":ready"}, REQ_READY, id ? 2'b10 : 2'b01);
    @(posedge CLK);
    #1 REQ_VALID[id] = 1'b0;
    @(negedge CLK);
    t = 1;
    check({tag, ":ce"}, ALU_CE, 1'b1);
    check({tag, ":in_valid"}, ALU_IN_VALID, inv);
    check({tag, ":alu_opa"}, ALU_OPA, opa);
    check({tag, ":alu_cmd"}, ALU_CMD, cmd);
    check({tag, ":ready_busy"}, REQ_READY, 2'b00);
    while (RSP_VALID !== 1'b1 && t < 20) begin
      @(negedge CLK);
      t++;
    end
    check({tag, ":latency"}, t, exp_lat + 1);
    check({tag, ":rsp_id"}, RSP_ID, id);
    check({tag, ":rsp_res"}, RSP_RES, exp_res);
    check({tag, ":rsp_mul"}, RSP_MUL_RES, exp_mul);
    check({tag, ":rsp_flags"}, RSP_FLAGS, exp_flags);
    check({tag, ":ce_resp"}, ALU_CE, 1'b0);
    @(negedge CLK);
    check({tag, ":pulse"}, RSP_VALID, 1'b0);
    check({tag, ":res_hold"}, RSP_RES, exp_res);
  endtask

  initial begin
    int t;
    int last_cyc;
    logic [1:0] g;

    RST          = 1'b1;
    REQ_VALID    = 2'b11;
    REQ_OPA      = '0;
    REQ_OPB      = '0;
    REQ_CMD      = '0;
    REQ_MODE     = '0;
    REQ_CIN      = '0;
    REQ_IN_VALID = '0;
    repeat (2) @(negedge CLK);
    check("rst:ready_in_reset", REQ_READY, 2'b00);
    REQ_VALID = 2'b00;
    RST       = 1'b0;
    @(negedge CLK);
    check("rst:rsp_valid", RSP_VALID, 1'b0);
    check("rst:ce", ALU_CE, 1'b0);
    check("rst:alu_opa", ALU_OPA, 8'h00);
    check("rst:rsp_res", RSP_RES, 9'h000);
    check("rst:rsp_flags", RSP_FLAGS, 6'h00);
    check("rst:ready_idle", REQ_READY, 2'b00);

    run_op("add0", 1'b0, 8'h0F, 8'h02, 4'b0000, 1'b1, 2'b11, 2, 9'h011, 16'h0000, 6'b001000);
    run_op("mul1", 1'b1, 8'h0F, 8'h02, 4'b1001, 1'b1, 2'b11, 3, 9'h000, 16'h001E, 6'b001000);
    run_op("err0", 1'b0, 8'h0F, 8'h02, 4'b1100, 1'b0, 2'b10, 2, 9'h000, 16'h0000, 6'b001001);

    // Fairness and back-to-back throughput under constant contention.
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    set_req(1'b0, 8'h01, 8'h02, 4'b0000, 1'b1, 1'b0, 2'b11);
    set_req(1'b1, 8'h10, 8'h20, 4'b0000, 1'b1, 1'b0, 2'b11);
    REQ_VALID = 2'b11;
    #1;
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (REQ_READY === 2'b00 && t < 20) begin
        @(negedge CLK);
        t++;
      end
      g = REQ_READY;
      check($sformatf("rr:grant%0d", k), g, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) check($sformatf("rr:spacing%0d", k), cyc_now - last_cyc, 4);
      last_cyc = cyc_now;
      @(posedge CLK);
      @(negedge CLK);
    end
    REQ_VALID = 2'b00;
    repeat (5) @(negedge CLK);

    // Reset while a multiply is waiting.
    set_req(1'b1, 8'h0F, 8'h02, 4'b1001, 1'b1, 1'b0, 2'b11);
    REQ_VALID = 2'b10;
    #1;
    t = 0;
    while (REQ_READY[1] !== 1'b1 && t < 20) begin
      @(negedge CLK);
      t++;
    end
    check("abort:ready", REQ_READY, 2'b10);
    @(posedge CLK);
    #1 REQ_VALID = 2'b00;
    repeat (2) @(negedge CLK);
    check("abort:ce_wait", ALU_CE, 1'b1);
    RST = 1'b1;
    set_req(1'b0, 8'h0F, 8'h02, 4'b0000, 1'b1, 1'b0, 2'b11);
    REQ_VALID = 2'b11;
    @(negedge CLK);
    check("abort:rsp_valid", RSP_VALID, 1'b0);
    check("abort:ce", ALU_CE, 1'b0);
    check("abort:in_valid", ALU_IN_VALID, 2'b00);
    check("abort:alu_opa", ALU_OPA, 8'h00);
    check("abort:alu_cmd", ALU_CMD, 4'h0);
    check("abort:alu_mode", ALU_MODE, 1'b0);
    check("abort:rsp_mul", RSP_MUL_RES, 16'h0000);
    check("abort:ready_rst", REQ_READY, 2'b00);
    RST = 1'b0;
    #1;
    check("abort:regrant", REQ_READY, 2'b01);
    @(posedge CLK);
    #1 REQ_VALID = 2'b00;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (RSP_VALID !== 1'b1 && t < 20);
    check("abort:latency", t, 3);
    check("abort:rsp_id", RSP_ID, 1'b0);
    check("abort:rsp_res", RSP_RES, 9'h011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
